conv_kxk_stream: RTL and testbench

Parametrised successor to the fixed 3x3-on-4x4 convolution controller. It accepts a KxK kernel and an NxN input map over valid/ready streams, buffers both locally, and computes the (N-K+1)^2 valid-convolution outputs with one signed MAC per cycle. Results leave in row-major order on a backpressured output stream, with optional ReLU and saturation. Weights can be reused across maps without reloading. The block sits between the feature-map loader and the downstream accumulation/pooling stage.

---
 rtl/conv_kxk_stream.sv | 237 +++++++++++++++++++++++
 tb/tb_conv_kxk_stream.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/conv_kxk_stream.sv
// KxK valid convolution over an NxN map. Kernel and map arrive on
// valid/ready streams and are buffered locally. One signed MAC is done per
// cycle, and each result leaves on a backpressured stream after optional
// ReLU and saturation.
module conv_kxk_stream #(
   parameter int DW = 8,
   parameter int K  = 3,
   parameter int N  = 4,
   parameter int AW = 2*DW + $clog2(K*K)
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic          reuse_w_i,
   input  logic          relu_en_i,
   input  logic          sat_en_i,
   input  logic          abort_i,
   input  logic          w_valid_i,
   output logic          w_ready_o,
   input  logic [DW-1:0] w_data_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [AW-1:0] out_data_o,
   output logic          out_last_o,
   output logic          busy_o,
   output logic          done_o
);

   localparam int KK  = K*K;
   localparam int NN  = N*N;
   localparam int P   = N-K+1;
   localparam int PW2 = 2*DW;
   localparam int IW  = (NN > 1) ? $clog2(NN) : 1;
   localparam int WAW = (KK > 1) ? $clog2(KK) : 1;
   localparam int KW  = (K > 1)  ? $clog2(K)  : 1;
   localparam int PW  = (P > 1)  ? $clog2(P)  : 1;

   localparam logic [KW-1:0] K_LAST  = KW'(K-1);
   localparam logic [PW-1:0] P_LAST  = PW'(P-1);
   localparam logic [IW-1:0] KK_LAST = IW'(KK-1);
   localparam logic [IW-1:0] NN_LAST = IW'(NN-1);
   localparam logic signed [AW-1:0] SMAX = AW'((1 << (DW-1)) - 1);
   localparam logic signed [AW-1:0] SMIN = AW'(-(1 << (DW-1)));

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD_W, S_LOAD_X, S_COMPUTE, S_OUTPUT, S_DONE
   } state_e;

   state_e state_q;
   logic [IW-1:0] idx_q;
   logic [PW-1:0] r_q, c_q;
   logic [KW-1:0] kr_q, kc_q;
   logic signed [AW-1:0] acc_q;
   logic relu_q, sat_q;
   logic w_ready_q, in_ready_q, out_valid_q, out_last_q, busy_q, done_q;

   logic [DW-1:0] w_mem_q [KK];
   logic [DW-1:0] x_mem_q [NN];

   logic w_we, x_we;
   logic [IW-1:0] xa;
   logic [WAW-1:0] wa;
   logic signed [PW2-1:0] prod;
   logic signed [AW-1:0] prod_ext, relu_v, post_v;

   // Buffer writes; an abort in the same cycle discards the beat.
   assign w_we = (state_q == S_LOAD_W) & w_valid_i & ~abort_i;
   assign x_we = (state_q == S_LOAD_X) & in_valid_i & ~abort_i;

   // Kernel store: survives abort and reuse, cleared only by reset
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < KK; i++) w_mem_q[i] <= '0;
      end else if (w_we) begin
         w_mem_q[idx_q[WAW-1:0]] <= w_data_i;
      end
   end

   // Map store
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NN; i++) x_mem_q[i] <= '0;
      end else if (x_we) begin
         x_mem_q[idx_q] <= in_data_i;
      end
   end

   // Window addressing and the full-precision signed product
   always_comb begin
      xa       = IW'((int'(r_q) + int'(kr_q)) * N + int'(c_q) + int'(kc_q));
      wa       = WAW'(int'(kr_q) * K + int'(kc_q));
      prod     = PW2'($signed(x_mem_q[xa])) * PW2'($signed(w_mem_q[wa]));
      prod_ext = AW'(prod);
   end

   // Post-processing: ReLU first, then clamp to the DW range
   always_comb begin
      relu_v = (relu_q && acc_q[AW-1]) ? '0 : acc_q;
      post_v = relu_v;
      if (sat_q) begin
         if (relu_v > SMAX)      post_v = SMAX;
         else if (relu_v < SMIN) post_v = SMIN;
      end
   end

   // Control FSM with counters, accumulator and registered handshakes
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         r_q         <= '0;
         c_q         <= '0;
         kr_q        <= '0;
         kc_q        <= '0;
         acc_q       <= '0;
         relu_q      <= 1'b0;
         sat_q       <= 1'b0;
         w_ready_q   <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else if (abort_i) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         r_q         <= '0;
         c_q         <= '0;
         kr_q        <= '0;
         kc_q        <= '0;
         w_ready_q   <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  relu_q <= relu_en_i;
                  sat_q  <= sat_en_i;
                  busy_q <= 1'b1;
                  idx_q  <= '0;
                  if (reuse_w_i) begin
                     state_q    <= S_LOAD_X;
                     in_ready_q <= 1'b1;
                  end else begin
                     state_q   <= S_LOAD_W;
                     w_ready_q <= 1'b1;
                  end
               end
            end
            S_LOAD_W: begin
               if (w_valid_i) begin
                  if (idx_q == KK_LAST) begin
                     idx_q      <= '0;
                     w_ready_q  <= 1'b0;
                     in_ready_q <= 1'b1;
                     state_q    <= S_LOAD_X;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            S_LOAD_X: begin
               if (in_valid_i) begin
                  if (idx_q == NN_LAST) begin
                     idx_q      <= '0;
                     in_ready_q <= 1'b0;
                     r_q        <= '0;
                     c_q        <= '0;
                     kr_q       <= '0;
                     kc_q       <= '0;
                     state_q    <= S_COMPUTE;
                  end else begin
                     idx_q <= idx_q + 1'b1;
                  end
               end
            end
            S_COMPUTE: begin
               // first tap overwrites so no stale sum leaks between outputs
               acc_q <= (kr_q == '0 && kc_q == '0) ? prod_ext : acc_q + prod_ext;
               if (kc_q == K_LAST) begin
                  kc_q <= '0;
                  if (kr_q == K_LAST) begin
                     kr_q        <= '0;
                     out_valid_q <= 1'b1;
                     out_last_q  <= (r_q == P_LAST) && (c_q == P_LAST);
                     state_q     <= S_OUTPUT;
                  end else begin
                     kr_q <= kr_q + 1'b1;
                  end
               end else begin
                  kc_q <= kc_q + 1'b1;
               end
            end
            S_OUTPUT: begin
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (out_last_q) begin
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     if (c_q == P_LAST) begin
                        c_q <= '0;
                        r_q <= r_q + 1'b1;
                     end else begin
                        c_q <= c_q + 1'b1;
                     end
                     state_q <= S_COMPUTE;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign w_ready_o   = w_ready_q;
   assign in_ready_o  = in_ready_q;
   assign out_valid_o = out_valid_q;
   assign out_last_o  = out_last_q;
   assign out_data_o  = post_v;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Directed bench for conv_kxk_stream at default parameters (DW=8, K=3, N=4).
module tb_conv_kxk_stream;

   localparam int DW = 8;
   localparam int K  = 3;
   localparam int N  = 4;
   localparam int AW = 20;

   logic clk = 1'b0, rst_n = 1'b0;
   logic start = 1'b0, reuse = 1'b0, relu = 1'b0, sat = 1'b0, abort = 1'b0;
   logic w_valid = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [DW-1:0] w_data = '0, in_data = '0;
   logic w_ready, in_ready, out_valid, out_last, busy, done;
   logic [AW-1:0] out_data;

   int checks = 0, failures = 0;
   int cyc = 0, done_cnt = 0, wr_cnt = 0;
   int t_last, dc0, wr0;

   int W_ID[9], W_ONE[9], W_NEG[9], W_127[9];
   int X_SEQ[16], X_127[16];
   int ex[4];

   conv_kxk_stream #(.DW(DW), .K(K), .N(N), .AW(AW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .reuse_w_i(reuse),
      .relu_en_i(relu), .sat_en_i(sat), .abort_i(abort),
      .w_valid_i(w_valid), .w_ready_o(w_ready), .w_data_i(w_data),
      .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
      .out_last_o(out_last), .busy_o(busy), .done_o(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;
   always @(posedge clk) if (w_ready) wr_cnt <= wr_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic rw, input logic rl, input logic st);
      start = 1'b1; reuse = rw; relu = rl; sat = st;
      step();
      start = 1'b0;
      chk("busy_after_start", {31'b0, busy}, 1);
      if (rw) chk("in_ready_after_start", {31'b0, in_ready}, 1);
      else    chk("w_ready_after_start", {31'b0, w_ready}, 1);
   endtask

   task automatic send_w(input int w[9]);
      w_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         w_data = DW'(w[i]);
         step();
      end
      w_valid = 1'b0;
   endtask

   task automatic send_x(input int x[16], output int t);
      in_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = DW'(x[i]);
         step();
      end
      in_valid = 1'b0;
      t = cyc;
   endtask

   // Drain four results; optionally stall output stall_k for 5 cycles.
   task automatic get_outs(input int e[4], input int t, input int stall_k, input int total);
      logic [AW-1:0] eo;
      int n;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         eo = AW'(e[k]);
         n = 0;
         while (!out_valid && n < 100) begin
            step();
            n++;
         end
         chk("out_valid_arrives", {31'b0, out_valid}, 1);
         if (k == stall_k) begin
            out_ready = 1'b0;
            for (int s = 0; s < 5; s++) begin
               step();
               chk("stall_valid_held", {31'b0, out_valid}, 1);
               chk("stall_data_stable", 32'(out_data), 32'(eo));
            end
            out_ready = 1'b1;
         end
         chk("out_data", 32'(out_data), 32'(eo));
         chk("out_last", {31'b0, out_last}, {31'b0, (k == 3)});
         step();
         if (k == 0 && stall_k != 0) chk("first_handshake_latency", 32'(cyc - t), 32'(K*K+1));
      end
      out_ready = 1'b0;
      chk("job_length", 32'(cyc - t), 32'(total));
      chk("done_pulse", {31'b0, done}, 1);
      chk("busy_during_done", {31'b0, busy}, 1);
      step();
      chk("done_drops", {31'b0, done}, 0);
      chk("busy_drops", {31'b0, busy}, 0);
   endtask

   initial begin
      W_ID  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
      W_ONE = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
      W_NEG = '{-1, -1, -1, -1, -1, -1, -1, -1, -1};
      W_127 = '{127, 127, 127, 127, 127, 127, 127, 127, 127};
      for (int i = 0; i < 16; i++) begin
         X_SEQ[i] = i + 1;
         X_127[i] = 127;
      end

      // reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_w_ready", {31'b0, w_ready}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 0);
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_out_last", {31'b0, out_last}, 0);
      chk("rst_done", {31'b0, done}, 0);
      chk("rst_out_data", 32'(out_data), 0);
      rst_n = 1'b1;
      step();

      // identity kernel
      start_job(1'b0, 1'b0, 1'b0);
      send_w(W_ID);
      send_x(X_SEQ, t_last);
      ex = '{6, 7, 10, 11};
      get_outs(ex, t_last, -1, 40);

      // all-ones kernel
      start_job(1'b0, 1'b0, 1'b0);
      send_w(W_ONE);
      send_x(X_SEQ, t_last);
      ex = '{54, 63, 90, 99};
      get_outs(ex, t_last, -1, 40);

      // 127 everywhere, no saturation
      start_job(1'b0, 1'b0, 1'b0);
      send_w(W_127);
      send_x(X_127, t_last);
      ex = '{145161, 145161, 145161, 145161};
      get_outs(ex, t_last, -1, 40);

      // same kernel reused, saturation on; weight port must stay idle
      wr0 = wr_cnt;
      start_job(1'b1, 1'b0, 1'b1);
      send_x(X_127, t_last);
      ex = '{127, 127, 127, 127};
      get_outs(ex, t_last, -1, 40);
      chk("reuse_no_w_ready", 32'(wr_cnt - wr0), 0);

      // negative kernel with ReLU
      start_job(1'b0, 1'b1, 1'b0);
      send_w(W_NEG);
      send_x(X_SEQ, t_last);
      ex = '{0, 0, 0, 0};
      get_outs(ex, t_last, -1, 40);

      // negative kernel reused, ReLU off
      start_job(1'b1, 1'b0, 1'b0);
      send_x(X_SEQ, t_last);
      ex = '{-54, -63, -90, -99};
      get_outs(ex, t_last, -1, 40);

      // backpressure on the second output
      start_job(1'b0, 1'b0, 1'b0);
      send_w(W_ONE);
      send_x(X_SEQ, t_last);
      ex = '{54, 63, 90, 99};
      get_outs(ex, t_last, 1, 45);

      // abort while computing: no done, back to idle
      dc0 = done_cnt;
      start_job(1'b1, 1'b0, 1'b0);
      send_x(X_SEQ, t_last);
      repeat (3) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", {31'b0, busy}, 0);
      chk("abort_out_valid", {31'b0, out_valid}, 0);
      chk("abort_done", {31'b0, done}, 0);
      repeat (12) step();
      chk("abort_no_done", 32'(done_cnt - dc0), 0);
      chk("abort_idle_out_valid", {31'b0, out_valid}, 0);

      // reuse after abort still sees the all-ones kernel
      wr0 = wr_cnt;
      start_job(1'b1, 1'b0, 1'b0);
      send_x(X_SEQ, t_last);
      ex = '{54, 63, 90, 99};
      get_outs(ex, t_last, -1, 40);
      chk("reuse_after_abort_no_w_ready", 32'(wr_cnt - wr0), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
